dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests issued by the EX/MEM stage of the pipelined MIPS datapath.
- Replaces the zero-latency combinational data memory with a handshaked, multicycle word memory.
- Drives a stall back to the pipeline while an access is outstanding.
- Single clock domain; sits between the EX/MEM buffer outputs and the MEM/WB buffer inputs.

Parameters:
- DEPTH_LOG2, 8, log2 of number of 32-bit words (256 words).
- LATENCY, 2, wait cycles between acceptance and access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present (memread or memwrite asserted)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (register read data 2)
- req_ready  out  1  responder can accept a request
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned or out-of-range address
- stall  out  1  freeze PC, IF/ID and ID/EX while high

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, captured registers 0.
  - req_ready is 1 during and after reset.
  - Memory array contents are not reset.
- State machine (dmem_state_t):
  - IDLE -> WAIT: on req_valid && req_ready. Capture write, addr, wdata; cnt <= LATENCY-1.
  - WAIT: while cnt != 0, cnt <= cnt-1.
  - WAIT -> RESP: when cnt == 0. Perform the access on this edge; register resp_rdata and resp_err.
  - RESP -> IDLE: unconditionally after one cycle. There is no response backpressure.
- Timing:
  - req_ready = (state == IDLE).
  - resp_valid = (state == RESP).
  - resp_valid is high for exactly the one cycle following the LATENCY-th edge after the accepting edge.
  - Total latency is LATENCY+1 cycles including the request cycle.
- Stall:
  - stall = (state == WAIT) || (state == IDLE && req_valid).
  - stall is 0 in RESP, so the pipeline advances on the RESP cycle and MEM/WB samples resp_rdata.
- Address checks:
  - Word index = req_addr[DEPTH_LOG2+1:2].
  - Error when req_addr[1:0] != 0, or when any bit of req_addr[31:DEPTH_LOG2+2] is 1.
  - On error: no write, resp_rdata = 0, resp_err = 1.
- Store: array written on the WAIT -> RESP edge; resp_rdata = 0.
- Load: resp_rdata = array[index] as sampled on the WAIT -> RESP edge.
- Back-to-back requests: requests presented in WAIT or RESP are ignored (req_ready = 0). The requester holds req_valid; acceptance occurs in the following IDLE cycle.
- Reset mid-operation: a pending access is aborted. No write occurs unless the WAIT -> RESP edge had already passed. No resp_valid is produced for an aborted request.
- Request inputs are sampled only at acceptance; later changes do not affect the access in flight.

Optional Feature:
- Macro DMEM_BYTE_WRITE_EN.
- Defined:
  - Adds port req_be (in, 4 bits).
  - On a store, only bytes with req_be[i] = 1 are written (byte i = bits 8i+7:8i).
  - req_be is captured at acceptance. Load behaviour is unchanged.
  - Alignment check remains word-level.
- Undefined: port absent; stores write the full word.

Decomposition:
- Package dmem_pkg:
  - typedef dmem_state_t {IDLE, WAIT, RESP}
  - WORD_W = 32
  - Default values for DEPTH_LOG2 and LATENCY.
- Sub-module dmem_array:
  - Synchronous single-port RAM with write enable, optional byte enables, and registered read.
  - Instantiated once.
  - FSM, counter, address checking and stall logic remain in dmem_responder.

Test Plan:
- Reset checks: assert rst mid-WAIT during a store to addr 0x10 -> outputs return to reset values immediately; a later load of 0x10 returns the prior contents (store aborted).
- Store then load (LATENCY = 2):
  - Store 0xDEADBEEF to 0x00000040 -> resp_valid 1 cycle, 2 edges after acceptance, resp_err 0, resp_rdata 0.
  - Load 0x40 -> resp_rdata 0xDEADBEEF.
- Stall shape (LATENCY = 2): req_valid held with a load -> stall sequence 1,1,1,0 across request, WAIT, WAIT, RESP; req_ready 1,0,0,0.
- Misaligned access: store to 0x42 -> resp_err 1, resp_rdata 0; a subsequent load of 0x40 is unchanged.
- Out-of-range access: load from 0x00000400 (DEPTH_LOG2 = 8) -> resp_err 1, resp_rdata 0.
- Byte enables (DMEM_BYTE_WRITE_EN, word 0x40 holding 0xDEADBEEF): store 0x11223344 with req_be = 4'b0101 -> load of 0x40 returns 0xDE22BE44.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional byte-enable stores are selected by DMEM_BYTE_WRITE_EN.
package dmem_pkg;

    localparam int WORD_W         = 32;
    localparam int DEPTH_LOG2_DEF = 8;
    localparam int LATENCY_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte write enables and a registered read port.
// Read register returns zero for write cycles so stores respond with 0.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? '0 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multicycle data memory for the MEM stage, with pipeline stall.
// Define DMEM_BYTE_WRITE_EN to add the req_be byte-enable port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
`ifdef DMEM_BYTE_WRITE_EN
    ,
    input  logic [3:0]        req_be
`endif
);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              err_q;

    logic              accept;
    logic              access;
    logic              addr_err;
    logic [WORD_W-1:0] arr_rdata;

    assign accept = (state_q == IDLE) && req_valid;
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);

    // Word-level alignment plus any address bit above the array range.
    assign addr_err = (|addr_q[1:0]) ||
                      (|addr_q[WORD_W-1:DEPTH_LOG2+2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= access && addr_err;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
                be_q    <= req_be;
`else
                be_q    <= 4'hF;
`endif
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (access && !addr_err),
        .we_i    (write_q),
        .be_i    (be_q),
        .addr_i  (addr_q[DEPTH_LOG2+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    // The read register is stale after an errored access, so mask it.
    assign resp_rdata = (resp_valid && !err_q) ? arr_rdata : '0;
    assign stall      = (state_q == WAIT) || accept;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY 2, DEPTH_LOG2 8).
module tb_dmem_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = 4'hF;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl[int];

    dmem_responder #(
        .DEPTH_LOG2 (8),
        .LATENCY    (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall)
`ifdef DMEM_BYTE_WRITE_EN
        ,
        .req_be     (req_be)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", e.name, resp_rdata, e.rdata);
                end
                checks++;
                if (resp_err !== e.err) begin
                    errors++;
                    $display("FAIL %s err: got %b want %b", e.name, resp_err, e.err);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s latency: resp at cycle %0d want %0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    function automatic exp_t model(input logic wr, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] be,
                                   input int acc, input string nm);
        exp_t e;
        e.err  = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
        e.rdata = 32'd0;
        e.cyc  = acc + L;
        e.name = nm;
        if (!e.err) begin
            if (wr) begin
                logic [31:0] w;
                w = mdl.exists(int'(a[9:2])) ? mdl[int'(a[9:2])] : 32'd0;
`ifndef DMEM_BYTE_WRITE_EN
                be = 4'hF;
`endif
                for (int i = 0; i < 4; i++)
                    if (be[i]) w[8*i +: 8] = d[8*i +: 8];
                mdl[int'(a[9:2])] = w;
            end else begin
                e.rdata = mdl.exists(int'(a[9:2])) ? mdl[int'(a[9:2])] : 32'hx;
            end
        end
        return e;
    endfunction

    task automatic send(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input string nm, input bit push = 1'b1);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s accept_timeout: req_ready=%b want 1", nm, req_ready);
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back(model(wr, a, d, be, cyc, nm));
        @(negedge clk);
        req_valid = 1'b0;
        req_write = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s resp_timeout: %0d outstanding want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_idle(input string nm);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, stall} !== 4'b1000) begin
            errors++;
            $display("FAIL %s ctrl: rdy/vld/err/stall=%b want 1000",
                     nm, {req_ready, resp_valid, resp_err, stall});
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL %s rdata: got %h want 0", nm, resp_rdata);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");
    endtask

    task automatic test_store_load();
        send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, "store_40");
        drain("store_40");
        send(1'b0, 32'h40, 32'h0, 4'hF, "load_40");
        drain("load_40");
    endtask

    task automatic test_stall_shape();
        logic [3:0] exp_stall;
        logic [3:0] exp_rdy;
        exp_stall = 4'b1110;
        exp_rdy   = 4'b1000;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (stall !== exp_stall[3-i] || req_ready !== exp_rdy[3-i]) begin
                errors++;
                $display("FAIL stall_shape[%0d]: stall=%b ready=%b want %b %b",
                         i, stall, req_ready, exp_stall[3-i], exp_rdy[3-i]);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
                sb.push_back(model(1'b0, 32'h40, 32'h0, 4'hF, cyc, "stall_load"));
            end
            if (i < 3) @(negedge clk);
        end
        req_valid = 1'b0;
        drain("stall_shape");
    endtask

    task automatic test_errors();
        send(1'b1, 32'h42, 32'h12345678, 4'hF, "misaligned_store");
        send(1'b0, 32'h40, 32'h0, 4'hF, "load_after_misaligned");
        send(1'b0, 32'h400, 32'h0, 4'hF, "out_of_range_load");
        send(1'b1, 32'h8000_0000, 32'h1, 4'hF, "out_of_range_store");
        drain("errors");
    endtask

    task automatic test_reset_abort();
        send(1'b1, 32'h10, 32'hA5A50001, 4'hF, "store_10");
        drain("store_10");
        send(1'b1, 32'h10, 32'h0BAD0BAD, 4'hF, "aborted_store", 1'b0);
        rst = 1'b1;
        chk_idle("mid_wait_reset");
        @(negedge clk);
        rst = 1'b0;
        drain("abort");
        send(1'b0, 32'h10, 32'h0, 4'hF, "load_10_after_abort");
        drain("load_10");
    endtask

    task automatic test_back_to_back();
        send(1'b1, 32'h20, 32'h0000_1111, 4'hF, "b2b_st20");
        send(1'b1, 32'h24, 32'h2222_0000, 4'hF, "b2b_st24");
        send(1'b0, 32'h20, 32'h0, 4'hF, "b2b_ld20");
        send(1'b0, 32'h24, 32'h0, 4'hF, "b2b_ld24");
        drain("back_to_back");
    endtask

    task automatic test_byte_enable();
`ifdef DMEM_BYTE_WRITE_EN
        send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, "be_init");
        send(1'b1, 32'h40, 32'h11223344, 4'b0101, "be_store");
        send(1'b0, 32'h40, 32'h0, 4'hF, "be_load");
        drain("byte_enable");
        checks++;
        if (mdl[16] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL be_model: got %h want DE22BE44", mdl[16]);
        end
`else
        send(1'b1, 32'h44, 32'hCAFEF00D, 4'b0101, "full_word_store");
        send(1'b0, 32'h44, 32'h0, 4'hF, "full_word_load");
        drain("full_word");
`endif
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h3FC, 32'h42, 32'h1000, 32'hFFFFFFFC};
        for (int i = 0; i < 5; i++)
            send(1'b1, addrs[i], $urandom, 4'hF, $sformatf("init%0d", i));
        for (int i = 0; i < 24; i++) begin
            int k;
            k = $urandom_range(0, 7);
            send($urandom_range(0, 1), addrs[k], $urandom,
                 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_stall_shape();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_byte_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
